// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants and enums for the register-file write-port
// controller.
//   NUM_REGS / ADDR_W / DATA_W : register-file geometry (16 x 16)
//   state_t                    : controller phase (zero sweep, normal run)
//   req_id_t                   : requester identity, also the arbiter pointer
package regfile_pkg;

    localparam int unsigned NUM_REGS = 16;
    localparam int unsigned ADDR_W   = 4;
    localparam int unsigned DATA_W   = 16;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_id_t;

endpackage

// File: rtl/regfile_wr_ctrl_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter for the register-file write port.
//   clk      in   rising-edge clock
//   rst      in   synchronous active-high reset, pointer returns to REQ_A
//   req[1:0] in   request vector, bit 0 = requester A, bit 1 = requester B
//   advance  in   a grant was taken this cycle
//   grant    out  one-hot grant (combinational from req and pointer)
module rr_arb2
    import regfile_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    req_id_t ptr;

    // The pointer only moves on contention; a lone requester never
    // steals priority from the other side.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= REQ_A;
        end else if (advance && (&req)) begin
            ptr <= (ptr == REQ_A) ? REQ_B : REQ_A;
        end
    end

    always_comb begin
        grant    = '0;
        grant[0] = req[0] && (!req[1] || (ptr == REQ_A));
        grant[1] = req[1] && (!req[0] || (ptr == REQ_B));
    end

endmodule

// File: rtl/regfile_wr_ctrl.sv
// regfile_wr_ctrl: write-port controller for the 16x16 register file.
// After reset it sweeps every register to zero (INIT), then shares the write
// port between writeback (A) and the load/multi-cycle return path (B) with
// round-robin arbitration (RUN). Writes to R0 are accepted but dropped.
//   clk, rst                 clock, synchronous active-high reset
//   a_valid/a_ready/a_addr/a_data   requester A handshake and payload
//   b_valid/b_ready/b_addr/b_data   requester B handshake and payload
//   rf_wen/rf_waddr/rf_wdata        registered register-file write port
//   init_done                       high once the zero sweep has finished
//   rd1_addr, rd2_addr              read addresses presented to the file
//   rd1/rd2_byp_valid, _byp_data    forwarding of the in-flight write
// Build option: define RF_BYPASS_EN to enable the read-port forwarding;
// otherwise the bypass outputs are tied to zero.
module regfile_wr_ctrl
    import regfile_pkg::*;
#(
    parameter int unsigned NUM_REGS = regfile_pkg::NUM_REGS,
    parameter int unsigned ADDR_W   = regfile_pkg::ADDR_W,
    parameter int unsigned DATA_W   = regfile_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic              rf_wen,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              init_done,
    input  logic [ADDR_W-1:0] rd1_addr,
    input  logic [ADDR_W-1:0] rd2_addr,
    output logic              rd1_byp_valid,
    output logic [DATA_W-1:0] rd1_byp_data,
    output logic              rd2_byp_valid,
    output logic [DATA_W-1:0] rd2_byp_data
);

    // One extra counter bit so the sweep can count past the last register
    // without wrapping; the count of NUM_REGS marks the sweep as finished.
    localparam logic [ADDR_W:0] SWEEP_LEN = (ADDR_W + 1)'(NUM_REGS);

    state_t              state;
    state_t              state_nxt;
    logic [ADDR_W:0]     sweep_cnt;
    logic [ADDR_W:0]     sweep_cnt_nxt;
    logic                rf_wen_nxt;
    logic [ADDR_W-1:0]   rf_waddr_nxt;
    logic [DATA_W-1:0]   rf_wdata_nxt;
    logic [1:0]          req;
    logic [1:0]          grant;
    logic                advance;

    // No grant while reset is asserted, so a requester never sees a
    // handshake that the reset is about to discard.
    assign req     = {b_valid, a_valid} & {2{(state == RUN) && !rst}};
    assign advance = |grant;
    assign a_ready = grant[0];
    assign b_ready = grant[1];

    assign init_done = (state == RUN);

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .advance (advance),
        .grant   (grant)
    );

    always_comb begin
        state_nxt     = state;
        sweep_cnt_nxt = sweep_cnt;
        rf_wen_nxt    = 1'b0;
        rf_waddr_nxt  = rf_waddr;
        rf_wdata_nxt  = rf_wdata;
        unique case (state)
            INIT: begin
                if (sweep_cnt < SWEEP_LEN) begin
                    rf_wen_nxt    = 1'b1;
                    rf_waddr_nxt  = sweep_cnt[ADDR_W-1:0];
                    rf_wdata_nxt  = '0;
                    sweep_cnt_nxt = sweep_cnt + 1'b1;
                end else begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                // R0 handshakes still complete; only the enable is withheld.
                if (grant[0]) begin
                    rf_wen_nxt   = (a_addr != '0);
                    rf_waddr_nxt = a_addr;
                    rf_wdata_nxt = a_data;
                end else if (grant[1]) begin
                    rf_wen_nxt   = (b_addr != '0);
                    rf_waddr_nxt = b_addr;
                    rf_wdata_nxt = b_data;
                end
            end
            default: begin
                state_nxt = INIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= INIT;
            sweep_cnt <= '0;
            rf_wen    <= 1'b0;
            rf_waddr  <= '0;
            rf_wdata  <= '0;
        end else begin
            state     <= state_nxt;
            sweep_cnt <= sweep_cnt_nxt;
            rf_wen    <= rf_wen_nxt;
            rf_waddr  <= rf_waddr_nxt;
            rf_wdata  <= rf_wdata_nxt;
        end
    end

`ifdef RF_BYPASS_EN
    assign rd1_byp_valid = rf_wen && (rf_waddr == rd1_addr) && (rd1_addr != '0);
    assign rd1_byp_data  = rf_wdata;
    assign rd2_byp_valid = rf_wen && (rf_waddr == rd2_addr) && (rd2_addr != '0);
    assign rd2_byp_data  = rf_wdata;
`else
    logic unused_rd_addr;
    assign unused_rd_addr = ^{rd1_addr, rd2_addr};
    assign rd1_byp_valid  = 1'b0;
    assign rd1_byp_data   = '0;
    assign rd2_byp_valid  = 1'b0;
    assign rd2_byp_data   = '0;
`endif

endmodule

// File: tb/tb_regfile_wr_ctrl.sv
// tb_regfile_wr_ctrl: self-checking bench for regfile_wr_ctrl.
// A cycle-level reference model (cycles since reset, a priority flag and the
// expected write-port contents) predicts every output each cycle; a shadow
// register file rebuilt from the DUT write port is compared against a golden
// file at the end of the random phase. Honours RF_BYPASS_EN.
module tb_regfile_wr_ctrl;

    localparam int unsigned AW = 4;
    localparam int unsigned DW = 16;
`ifdef RF_BYPASS_EN
    localparam logic BYP_ON = 1'b1;
`else
    localparam logic BYP_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          a_valid, a_ready, b_valid, b_ready;
    logic [AW-1:0] a_addr, b_addr, rf_waddr, rd1_addr, rd2_addr;
    logic [DW-1:0] a_data, b_data, rf_wdata, rd1_byp_data, rd2_byp_data;
    logic          rf_wen, init_done, rd1_byp_valid, rd2_byp_valid;

    regfile_wr_ctrl #(.NUM_REGS(16), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk           (clk),
        .rst           (rst),
        .a_valid       (a_valid),
        .a_ready       (a_ready),
        .a_addr        (a_addr),
        .a_data        (a_data),
        .b_valid       (b_valid),
        .b_ready       (b_ready),
        .b_addr        (b_addr),
        .b_data        (b_data),
        .rf_wen        (rf_wen),
        .rf_waddr      (rf_waddr),
        .rf_wdata      (rf_wdata),
        .init_done     (init_done),
        .rd1_addr      (rd1_addr),
        .rd2_addr      (rd2_addr),
        .rd1_byp_valid (rd1_byp_valid),
        .rd1_byp_data  (rd1_byp_data),
        .rd2_byp_valid (rd2_byp_valid),
        .rd2_byp_data  (rd2_byp_data)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    int            n_edges;   // rising edges since the last reset edge (capped at 17)
    logic          ptr_b;     // 1: B has priority on contention
    logic          m_wen;
    logic [AW-1:0] m_waddr;
    logic [DW-1:0] m_wdata;
    logic          m_known;   // addr/data prediction meaningful this cycle
    logic [DW-1:0] gold [16];
    logic [DW-1:0] act_file [16];
    logic          hs_a, hs_b, obs_a_rdy;
    logic          glog [$];

    always @(posedge clk) begin
        if (rf_wen === 1'b1) act_file[rf_waddr] <= rf_wdata;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic run, ea, eb, e1, e2;
        @(negedge clk);
        run = (n_edges >= 17);
        ea  = run && !rst && a_valid && (!b_valid || !ptr_b);
        eb  = run && !rst && b_valid && (!a_valid || ptr_b);
        obs_a_rdy = a_ready;
        chk("init_done", init_done, run);
        chk("a_ready", a_ready, ea);
        chk("b_ready", b_ready, eb);
        chk("rf_wen", rf_wen, m_wen);
        if (m_known) begin
            chk("rf_waddr", rf_waddr, m_waddr);
            chk("rf_wdata", rf_wdata, m_wdata);
        end
        e1 = BYP_ON && m_wen && (m_waddr == rd1_addr) && (rd1_addr != 0);
        e2 = BYP_ON && m_wen && (m_waddr == rd2_addr) && (rd2_addr != 0);
        chk("rd1_byp_valid", rd1_byp_valid, e1);
        chk("rd2_byp_valid", rd2_byp_valid, e2);
        if (e1) chk("rd1_byp_data", rd1_byp_data, m_wdata);
        if (e2) chk("rd2_byp_data", rd2_byp_data, m_wdata);
        if (!BYP_ON) begin
            chk("rd1_byp_data_off", rd1_byp_data, 0);
            chk("rd2_byp_data_off", rd2_byp_data, 0);
        end
        hs_a = ea;
        hs_b = eb;
        if (ea) glog.push_back(1'b0);
        if (eb) glog.push_back(1'b1);
        // Predict the cycle after the coming edge.
        if (rst) begin
            n_edges = 0; ptr_b = 1'b0; m_wen = 1'b0;
            m_waddr = '0; m_wdata = '0; m_known = 1'b1;
        end else if (n_edges < 16) begin
            n_edges++;
            m_wen = 1'b1; m_waddr = AW'(n_edges - 1); m_wdata = '0; m_known = 1'b1;
            gold[n_edges - 1] = '0;
        end else begin
            if (n_edges < 17) n_edges++;
            m_wen = 1'b0;
            if (ea || eb) begin
                m_waddr = ea ? a_addr : b_addr;
                m_wdata = ea ? a_data : b_data;
                m_wen   = (m_waddr != 0);
                m_known = m_wen;
                if (m_wen) gold[m_waddr] = m_wdata;
                if (a_valid && b_valid) ptr_b = !ptr_b;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; a_valid = 0; b_valid = 0; a_addr = '0; b_addr = '0;
        a_data = '0; b_data = '0; rd1_addr = '0; rd2_addr = '0;
        hs_a = 0; hs_b = 0; obs_a_rdy = 0;
        for (int i = 0; i < 16; i++) begin gold[i] = 'x; act_file[i] = 'x; end
        @(posedge clk);
        #1;
        n_edges = 0; ptr_b = 0; m_wen = 0; m_waddr = '0; m_wdata = '0; m_known = 1;
        tick();                                 // second reset cycle, checks reset state
        chk("reset_rf_wen", rf_wen, 0);
        chk("reset_init_done", init_done, 0);

        // Sweep, with both requesters knocking to confirm no ready leaks out.
        rst = 1'b0;
        a_valid = 1; a_addr = 4'd11; a_data = 16'h1111;
        b_valid = 1; b_addr = 4'd12; b_data = 16'h2222;
        rd1_addr = 4'd3; rd2_addr = 4'd0;
        repeat (17) tick();
        a_valid = 0; b_valid = 0;
        tick();                                 // cycle 17
        chk("sweep_init_done_c17", init_done, 1);
        chk("sweep_rf_wen_c17", rf_wen, 0);

        // Single write from A.
        a_valid = 1; a_addr = 4'd3; a_data = 16'hBEEF;
        tick();
        a_valid = 0;
        chk("a_write_wen", rf_wen, 1);
        chk("a_write_addr", rf_waddr, 3);
        chk("a_write_data", rf_wdata, 16'hBEEF);
        tick();

        // Single write from B.
        b_valid = 1; b_addr = 4'd7; b_data = 16'h1234;
        tick();
        b_valid = 0;
        chk("b_write_wen", rf_wen, 1);
        chk("b_write_addr", rf_waddr, 7);
        chk("b_write_data", rf_wdata, 16'h1234);
        tick();

        // Contention: six back-to-back grants must alternate starting at A.
        glog.delete();
        a_valid = 1; a_addr = 4'd1; a_data = 16'hA000;
        b_valid = 1; b_addr = 4'd2; b_data = 16'hB000;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (hs_a) a_data = a_data + 1'b1;
            if (hs_b) b_data = b_data + 1'b1;
        end
        a_valid = 0; b_valid = 0;
        chk("contention_grant_count", glog.size(), 6);
        for (int i = 0; i < glog.size() && i < 6; i++)
            chk($sformatf("contention_grant%0d", i), glog[i], i % 2);
        tick();

        // R0 write: handshake completes, write dropped, next write unaffected.
        a_valid = 1; a_addr = 4'd0; a_data = 16'hFFFF;
        tick();
        a_valid = 0;
        chk("r0_handshake", obs_a_rdy, 1);
        chk("r0_dropped_wen", rf_wen, 0);
        b_valid = 1; b_addr = 4'd5; b_data = 16'h5555;
        tick();
        b_valid = 0;
        chk("after_r0_wen", rf_wen, 1);
        chk("after_r0_addr", rf_waddr, 5);
        tick();

        // Bypass on the in-flight write.
        rd1_addr = 4'd9; rd2_addr = 4'd4;
        a_valid = 1; a_addr = 4'd9; a_data = 16'h00AA;
        tick();
        a_valid = 0;
        chk("byp_rd1_valid", rd1_byp_valid, BYP_ON);
        chk("byp_rd1_data", rd1_byp_data, BYP_ON ? 16'h00AA : 16'h0000);
        chk("byp_rd2_valid", rd2_byp_valid, 0);
        tick();

        // Random traffic; requesters hold their payload until accepted.
        for (int i = 0; i < 400; i++) begin
            tick();
            if (!a_valid || hs_a) begin
                a_valid = ($urandom_range(0, 3) != 0);
                a_addr  = AW'($urandom);
                a_data  = DW'($urandom);
            end
            if (!b_valid || hs_b) begin
                b_valid = ($urandom_range(0, 3) != 0);
                b_addr  = AW'($urandom);
                b_data  = DW'($urandom);
            end
            rd1_addr = AW'($urandom);
            rd2_addr = $urandom_range(0, 1) ? rf_waddr : AW'($urandom);
        end
        a_valid = 0; b_valid = 0;
        tick();
        tick();
        for (int r = 0; r < 16; r++)
            chk($sformatf("file_r%0d", r), act_file[r], gold[r]);

        // Reset in the cycle after a handshake.
        a_valid = 1; a_addr = 4'd6; a_data = 16'h6666;
        tick();
        a_valid = 0;
        chk("midrst_inflight_wen", rf_wen, 1);
        rst = 1'b1;
        tick();
        chk("midrst_wen", rf_wen, 0);
        chk("midrst_init_done", init_done, 0);
        rst = 1'b0;
        tick();
        chk("midrst_sweep_wen", rf_wen, 1);
        chk("midrst_sweep_addr", rf_waddr, 0);
        repeat (18) tick();
        chk("midrst_init_done_again", init_done, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
